// File: rtl/calc_pkg.sv
// Shared op encodings and FSM state type for the handshaked calculator.
package calc_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_ADD = 2'b00;
  localparam op_t OP_SUB = 2'b01;
  localparam op_t OP_MUL = 2'b10;
  localparam op_t OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per clock.
// The divide path exists only when CALC_DIV_EN is defined.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef CALC_DIV_EN
  input  logic               is_div,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] res_nxt
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH:0]   mul_sum;

`ifdef CALC_DIV_EN
  logic             div_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
`endif

  // {hi,lo} is the product register for MUL and {remainder,quotient} for DIV
  always_comb begin
    mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opa_q : {WIDTH{1'b0}})};
    res_nxt = {mul_sum, lo_q[WIDTH-1:1]};
`ifdef CALC_DIV_EN
    shl  = {hi_q, lo_q[WIDTH-1]};
    diff = shl - {1'b0, opb_q};
    if (div_q) begin
      // remainder stays below the divisor, so diff[WIDTH] is a clean borrow flag
      if (diff[WIDTH]) res_nxt = {shl[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0};
      else             res_nxt = {diff[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b1};
    end
`endif
  end

  assign done = (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      opa_q <= '0;
`ifdef CALC_DIV_EN
      div_q <= 1'b0;
      opb_q <= '0;
`endif
    end else if (start) begin
      cnt_q <= CW'(WIDTH);
      hi_q  <= '0;
      opa_q <= a;
`ifdef CALC_DIV_EN
      div_q <= is_div;
      opb_q <= b;
      lo_q  <= is_div ? a : b;
`else
      lo_q  <= b;
`endif
    end else if (cnt_q != '0) begin
      {hi_q, lo_q} <= res_nxt;
      cnt_q        <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/calc_seq_unit.sv
// Handshaked calculator: FSM, valid/ready handshake, ADD/SUB and result registers.
// Define CALC_DIV_EN to build the divider; otherwise DIV completes at once with err=1.
//
// state  | meaning
// S_IDLE | in_ready=1, waiting for a command
// S_CALC | iterative MUL/DIV running for WIDTH cycles
// S_DONE | out_valid=1, result held until out_ready
module calc_seq_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               neg,
  output logic               err
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               neg_q, neg_d;
  logic               err_q, err_d;
  logic               iter_start;
  logic               iter_done;
  logic [2*WIDTH-1:0] iter_res;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_mag;
  logic               a_lt_b;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign a_lt_b  = (a < b);
  assign sub_mag = a_lt_b ? (b - a) : (a - b);

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start   (iter_start),
`ifdef CALC_DIV_EN
    .is_div  (op == OP_DIV),
`endif
    .a       (a),
    .b       (b),
    .done    (iter_done),
    .res_nxt (iter_res)
  );

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    neg_d      = neg_q;
    err_d      = err_q;
    iter_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          case (op_t'(op))
            OP_ADD: begin
              result_d = {{(WIDTH-1){1'b0}}, add_sum};
              neg_d    = 1'b0;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            OP_SUB: begin
              result_d = {{WIDTH{1'b0}}, sub_mag};
              neg_d    = a_lt_b;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            OP_MUL: begin
              iter_start = 1'b1;
              state_d    = S_CALC;
            end
            OP_DIV: begin
`ifdef CALC_DIV_EN
              if (b == '0) begin
                result_d = {a, {WIDTH{1'b1}}};
                neg_d    = 1'b0;
                err_d    = 1'b1;
                state_d  = S_DONE;
              end else begin
                iter_start = 1'b1;
                state_d    = S_CALC;
              end
`else
              result_d = '0;
              neg_d    = 1'b0;
              err_d    = 1'b1;
              state_d  = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CALC: begin
        if (iter_done) begin
          result_d = iter_res;
          neg_d    = 1'b0;
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign neg       = neg_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_seq_unit.sv
// Scoreboard bench for calc_seq_unit at WIDTH=8; honours CALC_DIV_EN like the RTL.
module tb_calc_seq_unit;
  localparam int W  = 8;
  localparam int RW = 2 * W;

  typedef struct {
    logic [RW-1:0] res;
    logic          neg;
    logic          err;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] result;
  logic          neg;
  logic          err;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  calc_seq_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .neg       (neg),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.res = '0; e.neg = 1'b0; e.err = 1'b0; e.lat = 1;
    case (o)
      2'b00: e.res = RW'(x) + RW'(y);
      2'b01: begin
        if (x >= y) e.res = RW'(x - y);
        else begin e.res = RW'(y - x); e.neg = 1'b1; end
      end
      2'b10: begin e.res = RW'(x) * RW'(y); e.lat = W + 1; end
      default: begin
`ifdef CALC_DIV_EN
        if (y == 0) begin e.res = {x, {W{1'b1}}}; e.err = 1'b1; end
        else begin e.res = {x % y, x / y}; e.lat = W + 1; end
`else
        e.err = 1'b1;
`endif
      end
    endcase
    return e;
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    exp_t e;
    int   cyc;
    int   lat;
    logic busy_ok;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("ready_before_cmd", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("in_ready_busy", busy_ok, 1);
    chk("out_valid", out_valid, 1);
    chk("result", result, e.res);
    chk("neg", neg, e.neg);
    chk("err", err, e.err);
    chk("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", result, e.res);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_handoff_valid", out_valid, 0);
    chk("after_handoff_ready", in_ready, 1);
  endtask

  initial begin
    logic ov_seen;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_neg", neg, 0);
    chk("rst_err", err, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(2'b00, 8'd194, 8'd246, 0);
    do_op(2'b01, 8'd54, 8'd155, 0);
    do_op(2'b01, 8'd18, 8'd7, 1);
    do_op(2'b10, 8'd134, 8'd89, 0);
    do_op(2'b11, 8'd200, 8'd7, 0);
    do_op(2'b11, 8'd5, 8'd0, 0);
    do_op(2'b10, 8'd208, 8'd0, 5);
    do_op(2'b00, 8'd255, 8'd255, 0);
    do_op(2'b01, 8'd0, 8'd255, 0);
    do_op(2'b10, 8'd255, 8'd255, 0);
    do_op(2'b11, 8'd255, 8'd1, 0);
    do_op(2'b11, 8'd3, 8'd200, 2);

    // abort a MUL four cycles in
    op = 2'b10; a = 8'd255; b = 8'd255; in_valid = 1'b1;
    sb.push_back(model(2'b10, 8'd255, 8'd255));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_result", result, 0);
    ov_seen = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    repeat (14) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    chk("abort_no_valid", ov_seen, 0);
    chk("abort_ready_after", in_ready, 1);
    chk("abort_result_after", result, 0);
    do_op(2'b00, 8'd85, 8'd170, 0);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ry;
      ry = (i % 6 == 5) ? '0 : W'($urandom);
      do_op(2'($urandom), W'($urandom), ry, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
